// File: rtl/switch_debounce_pkg.sv
// switch_debounce_pkg: shared state encoding, default timing and counter sizing
package switch_debounce_pkg;
  typedef enum logic [2:0] {
    RELEASED,
    DEB_PRESS,
    HELD_DELAY,
    HELD_REPEAT,
    DEB_RELEASE
  } deb_state_t;
  localparam int DEF_N_SW = 4;
  localparam int DEF_DEB_CYCLES = 1_000_000;
  localparam int DEF_REP_EN = 1;
  localparam int DEF_REP_DELAY = 25_000_000;
  localparam int DEF_REP_PERIOD = 5_000_000;
  function automatic int cnt_width(input int deb, input int dly, input int per);
    int m;
    m = (deb > dly) ? deb : dly;
    m = (m > per) ? m : per;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/switch_debounce_ch.sv
// switch_debounce_ch: one channel of synchroniser, debounce FSM and press/release/repeat pulses
module switch_debounce_ch
  import switch_debounce_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int REP_EN     = DEF_REP_EN,
  parameter int REP_DELAY  = DEF_REP_DELAY,
  parameter int REP_PERIOD = DEF_REP_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_in,
  output logic sw_level,
  output logic sw_press,
  output logic sw_release
);
  localparam int CW = cnt_width(DEB_CYCLES, REP_DELAY, REP_PERIOD);
  localparam logic [CW-1:0] DEB_T = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] DLY_T = CW'(REP_DELAY - 1);
  localparam logic [CW-1:0] PER_T = CW'(REP_PERIOD - 1);
  logic s1, s;
  deb_state_t state;
  logic [CW-1:0] cnt, cnt_inc;
  assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
  // two-stage synchroniser for the asynchronous switch level
  always_ff @(posedge clk or negedge rst)
    if (!rst) {s, s1} <= 2'b00;
    else {s, s1} <= {s1, sw_in};
  // debounce FSM with registered level and single-cycle pulses
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state      <= RELEASED;
      cnt        <= '0;
      sw_level   <= 1'b0;
      sw_press   <= 1'b0;
      sw_release <= 1'b0;
    end else begin
      sw_press   <= 1'b0;
      sw_release <= 1'b0;
      cnt        <= cnt_inc;
      case (state)
        RELEASED: begin
          cnt <= '0;
          if (s) state <= DEB_PRESS;
        end
        DEB_PRESS:
          if (!s) state <= RELEASED;
          else if (cnt == DEB_T) begin
            state    <= HELD_DELAY;
            sw_level <= 1'b1;
            sw_press <= 1'b1;
            cnt      <= '0;
          end
        HELD_DELAY:
          if (!s) begin
            state <= DEB_RELEASE;
            cnt   <= '0;
          end else if (REP_EN != 0 && cnt == DLY_T) begin
            state    <= HELD_REPEAT;
            sw_press <= 1'b1;
            cnt      <= '0;
          end
        HELD_REPEAT:
          if (!s) begin
            state <= DEB_RELEASE;
            cnt   <= '0;
          end else if (cnt == PER_T) begin
            sw_press <= 1'b1;
            cnt      <= '0;
          end
        DEB_RELEASE:
          if (s) begin
            state <= HELD_DELAY;
            cnt   <= '0;
          end else if (cnt == DEB_T) begin
            state      <= RELEASED;
            sw_level   <= 1'b0;
            sw_release <= 1'b1;
          end
        default: state <= RELEASED;
      endcase
    end
endmodule

// File: rtl/switch_debounce.sv
// switch_debounce: N_SW independent debounced switch channels
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int N_SW       = DEF_N_SW,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int REP_EN     = DEF_REP_EN,
  parameter int REP_DELAY  = DEF_REP_DELAY,
  parameter int REP_PERIOD = DEF_REP_PERIOD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] sw_in,
  output logic [N_SW-1:0] sw_level,
  output logic [N_SW-1:0] sw_press,
  output logic [N_SW-1:0] sw_release
);
  for (genvar i = 0; i < N_SW; i++) begin : g_ch
    switch_debounce_ch #(
      .DEB_CYCLES(DEB_CYCLES),
      .REP_EN    (REP_EN),
      .REP_DELAY (REP_DELAY),
      .REP_PERIOD(REP_PERIOD)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .sw_in     (sw_in[i]),
      .sw_level  (sw_level[i]),
      .sw_press  (sw_press[i]),
      .sw_release(sw_release[i])
    );
  end
endmodule

// File: tb/tb_switch_debounce.sv
// tb_switch_debounce: directed and random checks against a run-length reference model
module tb_switch_debounce;
  localparam int DEB = 4;
  localparam int REPD = 10;
  localparam int REPP = 5;
  localparam int NS = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NS-1:0] sw_in = '0;
  logic [NS-1:0] sw_level, sw_press, sw_release;
  int vectors = 0;
  int errs = 0;
  logic [NS-1:0] d1, d2, lv, ep, er;
  int run [NS];
  int h [NS];
  switch_debounce #(
    .N_SW(NS), .DEB_CYCLES(DEB), .REP_EN(1), .REP_DELAY(REPD), .REP_PERIOD(REPP)
  ) dut (
    .clk(clk), .rst(rst), .sw_in(sw_in),
    .sw_level(sw_level), .sw_press(sw_press), .sw_release(sw_release)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [NS-1:0] got, input logic [NS-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    d1 = '0; d2 = '0; lv = '0; ep = '0; er = '0;
    for (int c = 0; c < NS; c++) begin run[c] = 0; h[c] = 0; end
  endtask
  // A level change is accepted after DEB+1 consecutive differing samples of s;
  // repeats fire REPD samples after the hold anchor, then every REPP.
  task automatic model_edge();
    logic [NS-1:0] s;
    if (!rst) begin model_reset(); return; end
    s = d2; d2 = d1; d1 = sw_in; ep = '0; er = '0;
    for (int c = 0; c < NS; c++) begin
      if (s[c] != lv[c]) begin
        run[c]++;
        if (run[c] == DEB + 1) begin
          lv[c] = s[c]; run[c] = 0; h[c] = 0;
          if (s[c]) ep[c] = 1'b1; else er[c] = 1'b1;
        end
      end else if (lv[c]) begin
        if (run[c] > 0) begin run[c] = 0; h[c] = 0; end
        else begin
          h[c]++;
          if (h[c] >= REPD && (h[c] - REPD) % REPP == 0) ep[c] = 1'b1;
        end
      end else run[c] = 0;
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_level", sw_level, lv);
    chk("model_press", sw_press, ep);
    chk("model_release", sw_release, er);
  endtask
  initial begin
    model_reset();
    sw_in = 4'hF;
    repeat (3) tick();
    rst = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("t1_press", sw_press, (i == 7) ? 4'hF : 4'h0);
      chk("t1_level", sw_level, (i >= 7) ? 4'hF : 4'h0);
    end
    sw_in = '0;
    repeat (20) tick();
    sw_in = 4'b0001;
    for (int i = 1; i <= 27; i++) begin
      tick();
      chk("t2_press", sw_press, (i == 7 || i == 17 || i == 22 || i == 27) ? 4'b0001 : 4'b0000);
    end
    sw_in = '0;
    repeat (20) tick();
    for (int i = 1; i <= 16; i++) begin
      sw_in[1] = (i <= 3) || (i == 5) || (i == 6);
      tick();
      chk("t3_press", {3'b0, sw_press[1]}, 4'b0);
      chk("t3_level", {3'b0, sw_level[1]}, 4'b0);
    end
    for (int i = 1; i <= 34; i++) begin
      sw_in[2] = !(i == 10 || i == 11 || i >= 26);
      tick();
      chk("t4_press", {3'b0, sw_press[2]}, {3'b0, i == 7 || i == 24});
      chk("t4_release", {3'b0, sw_release[2]}, {3'b0, i == 32});
    end
    sw_in = '0;
    repeat (20) tick();
    sw_in = 4'b1010;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("t5_press", sw_press, (i == 7) ? 4'b1010 : 4'b0000);
    end
    sw_in = '0;
    repeat (20) tick();
    sw_in = 4'b1000;
    repeat (19) tick();
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    chk("t6_async_level", sw_level, 4'b0);
    chk("t6_async_press", sw_press, 4'b0);
    repeat (2) tick();
    #2;
    rst = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("t6_press", sw_press, (i == 7) ? 4'b1000 : 4'b0000);
    end
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < NS; c++) if ($urandom_range(0, 9) == 0) sw_in[c] = ~sw_in[c];
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
